// File: rtl/slow_mem_responder.sv
// Fixed-latency line memory responder for the cache-to-memory interface.
// Captures one 128-bit line read or write in IDLE. It holds the request for
// LATENCY edges, then commits the write or loads the read data. The cycle
// after that, it pulses mem_ready for one cycle. One instance per cache port.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   mem_read   line read request, held until mem_ready
//   mem_write  line write request, held until mem_ready (wins over mem_read)
//   mem_addr   line address bits [31:4]; low IDX_W bits select the line
//   mem_wdata  write line data
//   mem_rdata  read line data, valid in the mem_ready cycle of a read
//   mem_ready  one-cycle completion pulse
//   busy       high while a request is in flight (BUSY or RESP)
module slow_mem_responder #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned IDX_W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         busy
);

   localparam int unsigned DATA_W = 128;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEPTH  = 2 ** IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Request copy taken in IDLE; the live inputs are ignored afterwards
   typedef struct packed {
      logic              is_write;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q;
   logic              cap_en_c;
   logic              commit_c;
   logic [DATA_W-1:0] mem [DEPTH];

   // Address bits above the index only alias lines
   generate
      if (IDX_W < 28) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^mem_addr[27:IDX_W];
      end
   endgenerate

   // Next-state, counter and commit decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_en_c = 1'b0;
      commit_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               cap_en_c = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               commit_c = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         mem_ready <= 1'b0;
         busy      <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_ready <= (state_d == RESP);
         busy      <= (state_d != IDLE);
         if (cap_en_c) begin
            req_q.is_write <= mem_write;
            req_q.idx      <= mem_addr[IDX_W-1:0];
            req_q.wdata    <= mem_wdata;
         end
         if (commit_c && !req_q.is_write) begin
            mem_rdata <= mem[req_q.idx];
         end
      end
   end

   // Line storage, deliberately not reset; a reset edge aborts a pending write
   always_ff @(posedge clk) begin
      if (rst_n && commit_c && req_q.is_write) begin
         mem[req_q.idx] <= req_q.wdata;
      end
   end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder. It runs a LATENCY=4 instance through a
// vector table plus reset sequences, and a LATENCY=1 instance for aliasing.
module tb_slow_mem_responder;

   localparam logic [127:0] D_A = 128'hDEADBEEF_00112233_44556677_8899AABB;
   localparam logic [127:0] D_B = 128'h0B0B0B0B_11111111_22222222_33333333;
   localparam logic [127:0] D_C = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
   localparam logic [127:0] D_D = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] D_E = 128'hEEEE0000_EEEE0000_EEEE0000_EEEE0000;
   localparam logic [127:0] D_F = 128'hF00DF00D_00000001_00000002_00000003;
   localparam logic [127:0] D_G = 128'h66666666_77777777_88888888_99999999;
   localparam logic [127:0] D_H = 128'h12121212_34343434_56565656_78787878;
   localparam logic [127:0] D_P = 128'h50505050_A0A0A0A0_50505050_A0A0A0A0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mem_read = 1'b0, mem_write = 1'b0;
   logic [27:0]  mem_addr = '0;
   logic [127:0] mem_wdata = '0;
   logic [127:0] mem_rdata;
   logic         mem_ready, busy;

   logic         r1_read = 1'b0, r1_write = 1'b0;
   logic [27:0]  r1_addr = '0;
   logic [127:0] r1_wdata = '0;
   logic [127:0] r1_rdata;
   logic         r1_ready, r1_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   slow_mem_responder #(.LATENCY(4), .IDX_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .busy(busy)
   );

   slow_mem_responder #(.LATENCY(1), .IDX_W(8)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .mem_read(r1_read), .mem_write(r1_write),
      .mem_addr(r1_addr), .mem_wdata(r1_wdata), .mem_rdata(r1_rdata),
      .mem_ready(r1_ready), .busy(r1_busy)
   );

   typedef struct {
      bit           rd;
      bit           wr;
      logic [27:0]  addr;
      logic [127:0] wd;
      bit           scr;
      logic [127:0] exp_rd;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [27:0] addr, input logic [127:0] wd);
      if (sel) begin
         r1_read = rd; r1_write = wr; r1_addr = addr; r1_wdata = wd;
      end else begin
         mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
      end
   endtask

   function automatic logic cur_ready(input bit sel);
      return sel ? r1_ready : mem_ready;
   endfunction

   function automatic logic cur_busy(input bit sel);
      return sel ? r1_busy : busy;
   endfunction

   function automatic logic [127:0] cur_rdata(input bit sel);
      return sel ? r1_rdata : mem_rdata;
   endfunction

   // Issue one request at a negedge while the DUT is idle, then wait for the pulse.
   // Check latency, read data, the single-cycle pulse and that rdata holds.
   task automatic run_txn(input bit sel, input bit rd, input bit wr,
                          input logic [27:0] addr, input logic [127:0] wd,
                          input bit scr, input logic [127:0] exp_rd,
                          input int lat, input string name);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      drive(sel, rd, wr, addr, wd);
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({name, "_busy"}, 128'(cur_busy(sel)), 128'(1));
            if (scr) drive(sel, rd, wr, 28'h0000040, '1);
         end
         if (cur_ready(sel)) seen = 1'b1;
      end
      chk_int({name, "_latency"}, n, lat + 1);
      chk({name, "_rdata"}, cur_rdata(sel), exp_rd);
      ready_cyc = cyc;
      drive(sel, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk({name, "_pulse_once"}, 128'(cur_ready(sel)), 128'(0));
      chk({name, "_rdata_hold"}, cur_rdata(sel), exp_rd);
   endtask

   initial begin
      int prev;
      int extra;

      //            rd    wr    addr          wdata scr   expected mem_rdata
      vecs[0]  = '{1'b0, 1'b1, 28'h0000010, D_A, 1'b0, 128'h0};
      vecs[1]  = '{1'b1, 1'b0, 28'h0000010, '0,  1'b0, D_A};
      vecs[2]  = '{1'b0, 1'b1, 28'h0000030, D_B, 1'b0, D_A};
      vecs[3]  = '{1'b0, 1'b1, 28'h0000020, D_C, 1'b0, D_A};
      vecs[4]  = '{1'b1, 1'b0, 28'h0000030, '0,  1'b0, D_B};
      vecs[5]  = '{1'b1, 1'b0, 28'h0000020, '0,  1'b0, D_C};
      vecs[6]  = '{1'b0, 1'b1, 28'h0000040, D_D, 1'b0, D_C};
      vecs[7]  = '{1'b0, 1'b1, 28'h0000050, D_E, 1'b1, D_C};
      vecs[8]  = '{1'b1, 1'b0, 28'h0000040, '0,  1'b0, D_D};
      vecs[9]  = '{1'b1, 1'b0, 28'h0000050, '0,  1'b0, D_E};
      vecs[10] = '{1'b1, 1'b1, 28'h0000060, D_F, 1'b0, D_E};
      vecs[11] = '{1'b1, 1'b0, 28'h0000060, '0,  1'b0, D_F};
      vecs[12] = '{1'b0, 1'b1, 28'h0000070, D_G, 1'b0, D_F};

      // Reset held for two cycles
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("reset_ready", 128'(mem_ready), 128'(0));
         chk("reset_rdata", mem_rdata, 128'h0);
         chk("reset_busy", 128'(busy), 128'(0));
      end
      rst_n = 1'b1;

      // Back-to-back table; each request issues in the IDLE cycle after the last pulse
      prev = 0;
      for (int i = 0; i < NVEC; i++) begin
         run_txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                 vecs[i].scr, vecs[i].exp_rd, 4, $sformatf("vec%0d", i));
         if (i > 0) chk_int($sformatf("vec%0d_spacing", i), ready_cyc - prev, 6);
         prev = ready_cyc;
      end

      // Reset two cycles into a write to line 0x70 aborts it
      drive(1'b0, 1'b0, 1'b1, 28'h0000070, D_H);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("abort_ready0", 128'(mem_ready), 128'(0));
      @(negedge clk);
      chk("abort_ready1", 128'(mem_ready), 128'(0));
      chk("abort_rdata", mem_rdata, 128'h0);
      chk("abort_busy", 128'(busy), 128'(0));
      rst_n = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_ready) extra++;
      end
      chk_int("abort_no_ready", extra, 0);
      run_txn(1'b0, 1'b1, 1'b0, 28'h0000070, '0, 1'b0, D_G, 4, "abort_old_data");

      // LATENCY=1 instance: out-of-range address aliases to index 0x05
      run_txn(1'b1, 1'b0, 1'b1, 28'h0000105, D_P, 1'b0, 128'h0, 1, "l1_write");
      run_txn(1'b1, 1'b1, 1'b0, 28'h0000005, '0, 1'b0, D_P, 1, "l1_alias_read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
Synthesizable memory-side responder for the cache-to-memory line interface used by both I_cache and D_cache. It accepts 128-bit line read and write requests, holds them for a programmable fixed latency, then commits the write or returns the read data with a one-cycle mem_ready pulse. It lets the CHIP-level caches close timing and be verified against a real responder instead of the testbench's behavioural slow memory. One instance serves one cache port.

Parameters:
LATENCY, 4, rising edges from request capture to mem_ready assertion; legal range 1..255
IDX_W, 8, line-index width; storage is 2**IDX_W lines of 128 bits, indexed by mem_addr[IDX_W+3:4]

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
mem_read  input  1  cache requests a line read; held until mem_ready is seen
mem_write  input  1  cache requests a line write; held until mem_ready is seen
mem_addr  input  28  line address, bits [31:4]; only [IDX_W+3:4] are decoded
mem_wdata  input  128  write line data; valid while mem_write is high
mem_rdata  output  128  read line data; valid in the mem_ready cycle of a read
mem_ready  output  1  one-cycle completion pulse for the current request
busy  output  1  high in BUSY and RESP states; observation only

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at an edge: state to IDLE, mem_ready=0, mem_rdata=0, busy=0, latency counter=0, captured request cleared. Storage array is not reset.
- States are IDLE, BUSY and RESP.
- IDLE, with mem_read or mem_write high at an edge:
  - Capture op, index and wdata.
  - Load counter with LATENCY-1.
  - Go to BUSY.
- IDLE, with no request: stay in IDLE.
- BUSY:
  - Counter decrements each edge.
  - At the edge where the counter is 0, go to RESP.
  - In the same edge, a write stores the captured wdata to mem[index], and a read loads mem_rdata from mem[index].
- RESP:
  - mem_ready=1 for exactly this one cycle.
  - At the next edge, go unconditionally to IDLE.
- Latency: a request captured at edge t gives mem_ready=1 in the cycle after edge t+LATENCY.
- mem_ready is a registered output, decoded from state RESP. It never stays high for two consecutive cycles.
- Request sampling:
  - Request inputs are sampled only in IDLE.
  - Changes to mem_addr, mem_wdata, mem_read or mem_write during BUSY or RESP are ignored, because the captured copies are used.
  - A request still asserted in the first IDLE cycle after RESP is treated as a new request. The cache must drop its request in that cycle, which it does by leaving its wait state on the mem_ready edge.
- Back-to-back requests: a write-back followed by an allocate read is two transactions, each taking LATENCY+1 cycles plus 1 IDLE cycle.
- mem_rdata:
  - Changes only at the edge entering RESP for a read.
  - Otherwise holds its last read value, including across writes.
  - Reads 0 after reset until the first read.
- Simultaneous mem_read and mem_write: treated as a write, and no read data is returned.
- Address aliasing: mem_addr bits above IDX_W+3 are ignored, so lines alias modulo 2**IDX_W.
- Reset mid-transaction: the transaction is aborted. A write still in BUSY is not committed, and no mem_ready is issued.
- Read-after-write to the same line in consecutive transactions returns the newly written data.
- LATENCY=1: BUSY lasts one cycle, with the counter loaded with 0.

Test Plan:
- Reset then write: rst_n=0 for 2 cycles, then write mem_addr=28'h0000010, wdata=128'hDEADBEEF_00112233_44556677_8899AABB -> mem_ready=0 and mem_rdata=0 during reset; mem_ready pulses once exactly 4 edges after capture (LATENCY=4).
- Read-back: read the same address -> mem_ready pulses once after 4 edges, with mem_rdata=128'hDEADBEEF_00112233_44556677_8899AABB; mem_rdata is unchanged in the following IDLE cycle.
- Write-back then allocate: write 0x...20=A, then read 0x...30 (preloaded B) issued on the IDLE cycle right after the first mem_ready -> two separate pulses 6 cycles apart; the read returns B; a later read of 0x20 returns A.
- Input instability: during BUSY, toggle mem_addr to 0x40 and mem_wdata to all-ones -> the captured address and data are used; mem[0x40] is unchanged.
- Corner cases:
  - Both mem_read and mem_write high -> the line is written and mem_rdata is unchanged.
  - rst_n=0 asserted two cycles into a write -> no mem_ready, and a later read of that line returns the old data.
- LATENCY=1 build with an address above range (IDX_W=8, mem_addr=28'h0000105) -> mem_ready on the second cycle after capture; the access aliases to index 0x05.
